// File: rtl/wb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | wb_pkg: shared widths, FIFO entry type and FSM encoding for the write-back  |
// |         port arbiter.                                                       |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package wb_pkg;

  localparam int REG_AW = 3;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } fsm_t;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | wb_fifo: circular buffer of parked memory returns with kill-by-address.     |
// |          WB_BYPASS_EN adds a youngest-live-match lookup port.               |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [REG_AW-1:0]        push_addr,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     kill_en,
  input  logic [REG_AW-1:0]        kill_addr,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]        byp_raddr,
  output logic                     byp_hit,
  output logic [DATA_W-1:0]        byp_data
`endif
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [PW:0]     r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < DEPTH; i++)
          if (r_mem[i].addr == kill_addr) r_mem[i].valid <= 1'b0;
      end
      if (push) begin
        r_mem[r_wr] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        r_wr        <= r_wr + PW'(1);
      end
      if (pop) r_rd <= r_rd + PW'(1);
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign head  = r_mem[r_rd];
  assign count = r_cnt;
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == (PW+1)'(DEPTH));

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last live match wins.
  always_comb begin
    logic [PW-1:0] idx;
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rd + PW'(i);
      if (((PW+1)'(i) < r_cnt) && r_mem[idx].valid && (r_mem[idx].addr == byp_raddr)) begin
        byp_hit  = 1'b1;
        byp_data = r_mem[idx].data;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | wb_port_arbiter: shares the register-file write port between ALU write-back |
// |   and memory returns. Optional macro WB_BYPASS_EN adds FIFO read bypass.    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     alu_valid,
  input  logic [REG_AW-1:0]        alu_addr,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_AW-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   pending_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]        byp_raddr,
  output logic                     byp_hit,
  output logic [DATA_W-1:0]        byp_data
`endif
);

  localparam int CW = $clog2(STARVE_MAX) + 1;
  localparam logic [CW-1:0] C_STARVE_LIM = CW'(STARVE_MAX - 1);

  wb_entry_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_bypass;
  logic        w_starving;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] r_starve;
  fsm_t        r_state;
  fsm_t        w_state_nxt;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (w_push),
    .push_addr (mem_addr),
    .push_data (mem_data),
    .pop       (w_pop),
    .kill_en   (alu_valid),
    .kill_addr (alu_addr),
    .head      (w_head),
    .count     (pending_cnt),
    .full      (w_full),
    .empty     (w_empty)
`ifdef WB_BYPASS_EN
    ,
    .byp_raddr (byp_raddr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data)
`endif
  );

  assign mem_ready = !resetn || !w_full;

  // ALU first, then FIFO head (killed heads pop silently), then empty-FIFO bypass.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    w_pop    = 1'b0;
    w_bypass = 1'b0;
    if (alu_valid) begin
      rf_we    = 1'b1;
      rf_waddr = alu_addr;
      rf_wdata = alu_data;
    end else if (!w_empty) begin
      w_pop = 1'b1;
      if (w_head.valid) begin
        rf_we    = 1'b1;
        rf_waddr = w_head.addr;
        rf_wdata = w_head.data;
      end
    end else if (mem_valid) begin
      w_bypass = 1'b1;
      rf_we    = 1'b1;
      rf_waddr = mem_addr;
      rf_wdata = mem_data;
    end
    if (!resetn) rf_we = 1'b0;
  end

  // A same-cycle mem return to the ALU's register is older, so it is dropped.
  assign w_push = mem_valid && mem_ready && !w_bypass &&
                  !(alu_valid && (alu_addr == mem_addr));

  assign w_starving = !w_empty && !w_pop;
  assign w_cnt_nxt  = !w_starving ? '0 :
                      (r_starve == C_STARVE_LIM) ? r_starve : r_starve + CW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve <= '0;
      r_state  <= NORMAL;
    end else begin
      r_starve <= w_cnt_nxt;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      NORMAL:  if (w_cnt_nxt == C_STARVE_LIM) w_state_nxt = STALL;
      STALL:   if (w_pop) w_state_nxt = NORMAL;
      default: w_state_nxt = NORMAL;
    endcase
  end

  assign pipe_stall = (r_state == STALL);

  a_no_alu_in_stall: assert property (@(posedge clk) disable iff (!resetn)
                                      pipe_stall |-> !alu_valid);

endmodule
`default_nettype wire
